id_branch_resolve: RTL and testbench

Instruction-decode stage that consumes the fetch stage's `IR`/`nPC` pair and closes the loop by driving `PCSrc`/`BrDest` back to it. Holds the IF/ID pipeline register, a 32×32 register file with writeback port, operand decode, and branch/jump resolution with wrong-path squash. Sits between fetch and execute in the single-issue MIPS pipeline. The PC is word-addressed, so sequential fetch is `PC + 1`.

---
 rtl/id_branch_resolve.sv | 136 +++++++++++++
 tb/tb_id_branch_resolve.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/id_branch_resolve.sv
// MIPS ID stage: IF/ID register, 32-entry register file with write-through bypass, and branch/jump resolution.
// Define ID_DELAY_SLOT_EN to keep the instruction after a taken branch; by default it is squashed.
module id_branch_resolve #(
   parameter int WORD = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [WORD-1:0] IR,
   input  logic [WORD-1:0] nPC,
   input  logic            stall,
   input  logic            RegWrite,
   input  logic [4:0]      WriteReg,
   input  logic [WORD-1:0] WriteData,
   output logic            PCSrc,
   output logic [WORD-1:0] BrDest,
   output logic            id_valid,
   output logic [WORD-1:0] id_nPC,
   output logic [5:0]      opcode,
   output logic [5:0]      funct,
   output logic [4:0]      rs,
   output logic [4:0]      rt,
   output logic [4:0]      rd,
   output logic [WORD-1:0] rdata1,
   output logic [WORD-1:0] rdata2,
   output logic [WORD-1:0] imm_ext
);

   localparam logic [5:0] OP_J   = 6'h02;
   localparam logic [5:0] OP_BEQ = 6'h04;
   localparam logic [5:0] OP_BNE = 6'h05;

   logic [WORD-1:0] id_ir_q, id_ir_d;
   logic [WORD-1:0] id_npc_q, id_npc_d;
   logic            id_valid_q, id_valid_d;
   logic [WORD-1:0] rf_q [NREG];
   logic            taken;

   // IF/ID pipeline register
   always_comb begin
      id_ir_d    = id_ir_q;
      id_npc_d   = id_npc_q;
      id_valid_d = id_valid_q;
      if (!stall) begin
`ifdef ID_DELAY_SLOT_EN
         id_ir_d    = IR;
         id_npc_d   = nPC;
         id_valid_d = 1'b1;
`else
         if (PCSrc) begin
            id_ir_d    = '0;
            id_npc_d   = nPC;
            id_valid_d = 1'b0;
         end else begin
            id_ir_d    = IR;
            id_npc_d   = nPC;
            id_valid_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id_ir_q    <= '0;
         id_npc_q   <= '0;
         id_valid_q <= 1'b0;
      end else begin
         id_ir_q    <= id_ir_d;
         id_npc_q   <= id_npc_d;
         id_valid_q <= id_valid_d;
      end
   end

   // Register file; entry 0 is never written, and reads of r0 are forced to zero anyway.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (RegWrite && (WriteReg != 5'd0)) begin
         rf_q[WriteReg] <= WriteData;
      end
   end

   assign opcode   = id_ir_q[31:26];
   assign rs       = id_ir_q[25:21];
   assign rt       = id_ir_q[20:16];
   assign rd       = id_ir_q[15:11];
   assign funct    = id_ir_q[5:0];
   assign imm_ext  = {{(WORD-16){id_ir_q[15]}}, id_ir_q[15:0]};
   assign id_nPC   = id_npc_q;
   assign id_valid = id_valid_q;

   // Two read ports (gi=0 -> rs, gi=1 -> rt), each bypassing the same-cycle writeback.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rp
      logic [4:0]      addr;
      logic [WORD-1:0] val;
      assign addr = (gi == 0) ? rs : rt;
      always_comb begin
         val = '0;
         if (addr != 5'd0) begin
            if (RegWrite && (WriteReg == addr)) val = WriteData;
            else                                val = rf_q[addr];
         end
      end
   end

   assign rdata1 = g_rp[0].val;
   assign rdata2 = g_rp[1].val;

   always_comb begin
      taken  = 1'b0;
      BrDest = id_npc_q;
      case (opcode)
         OP_BEQ: begin
            taken  = (rdata1 == rdata2);
            BrDest = id_npc_q + imm_ext;
         end
         OP_BNE: begin
            taken  = (rdata1 != rdata2);
            BrDest = id_npc_q + imm_ext;
         end
         OP_J: begin
            taken  = 1'b1;
            BrDest = {id_npc_q[WORD-1:WORD-6], id_ir_q[25:0]};
         end
         default: begin
            taken  = 1'b0;
            BrDest = id_npc_q;
         end
      endcase
   end

   // A stalled branch keeps its ID contents and redirects once the stall clears.
   assign PCSrc = id_valid_q & taken & ~stall;

endmodule

// File: tb/tb_id_branch_resolve.sv
// Directed bench for id_branch_resolve: decode, register file bypass, branch/jump redirect, squash, stall, reset.
module tb_id_branch_resolve;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IR, nPC;
   logic        stall, RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        PCSrc;
   logic [31:0] BrDest;
   logic        id_valid;
   logic [31:0] id_nPC;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] rdata1, rdata2, imm_ext;

   int n_vec = 0;
   int n_bad = 0;

`ifdef ID_DELAY_SLOT_EN
   localparam logic DS = 1'b1;
`else
   localparam logic DS = 1'b0;
`endif

   id_branch_resolve #(.WORD(32), .NREG(32)) dut (
      .clk(clk), .reset(reset), .IR(IR), .nPC(nPC), .stall(stall),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .PCSrc(PCSrc), .BrDest(BrDest), .id_valid(id_valid), .id_nPC(id_nPC),
      .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
      .rdata1(rdata1), .rdata2(rdata2), .imm_ext(imm_ext)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; IR = '0; nPC = '0; stall = 1'b0;
      RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
      @(posedge clk); @(posedge clk); #2;
      chk("rst_valid",  {31'd0, id_valid}, 32'd0);
      chk("rst_pcsrc",  {31'd0, PCSrc}, 32'd0);
      chk("rst_brdest", BrDest, 32'd0);
      chk("rst_npc",    id_nPC, 32'd0);
      chk("rst_opcode", {26'd0, opcode}, 32'd0);
      chk("rst_rdata1", rdata1, 32'd0);
      chk("rst_imm",    imm_ext, 32'd0);
      reset = 1'b1;

      // nop through the stage
      IR = 32'h0000_0000; nPC = 32'd1;
      tick(); #1;
      chk("nop_valid",  {31'd0, id_valid}, 32'd1);
      chk("nop_pcsrc",  {31'd0, PCSrc}, 32'd0);
      chk("nop_brdest", BrDest, 32'd1);

      // r1=5, r2=5, then beq r1,r2,+3 at nPC=10
      RegWrite = 1'b1; WriteReg = 5'd1; WriteData = 32'd5; tick();
      WriteReg = 5'd2; tick();
      RegWrite = 1'b0; IR = 32'h1022_0003; nPC = 32'd10;
      tick(); #1;
      chk("beq_rs",     {27'd0, rs}, 32'd1);
      chk("beq_rt",     {27'd0, rt}, 32'd2);
      chk("beq_rdata1", rdata1, 32'd5);
      chk("beq_rdata2", rdata2, 32'd5);
      chk("beq_imm",    imm_ext, 32'd3);
      chk("beq_pcsrc",  {31'd0, PCSrc}, 32'd1);
      chk("beq_brdest", BrDest, 32'd13);
      IR = 32'h0022_1820; nPC = 32'd11;      // add r3,r1,r2 on the wrong path
      tick(); #1;
      chk("slot_valid",  {31'd0, id_valid}, {31'd0, DS});
      chk("slot_npc",    id_nPC, 32'd11);
      chk("slot_rd",     {27'd0, rd}, DS ? 32'd3 : 32'd0);
      chk("slot_pcsrc",  {31'd0, PCSrc}, 32'd0);
      chk("slot_brdest", BrDest, 32'd11);
      tick(); #1;
      chk("add_valid", {31'd0, id_valid}, 32'd1);
      chk("add_rd",    {27'd0, rd}, 32'd3);
      chk("add_funct", {26'd0, funct}, 32'h20);

      // bne r1,r2,-4 at nPC=2: not taken, then taken via bypassed r2=6
      IR = 32'h1422_FFFC; nPC = 32'd2;
      tick(); #1;
      chk("bne_nt_pcsrc", {31'd0, PCSrc}, 32'd0);
      chk("bne_imm",      imm_ext, 32'hFFFF_FFFC);
      RegWrite = 1'b1; WriteReg = 5'd2; WriteData = 32'd6; #1;
      chk("bne_bypass",  rdata2, 32'd6);
      chk("bne_pcsrc",   {31'd0, PCSrc}, 32'd1);
      chk("bne_brdest",  BrDest, 32'hFFFF_FFFE);
      IR = 32'h0; nPC = 32'd3;
      tick(); RegWrite = 1'b0; #1;
      chk("bne_sq_valid", {31'd0, id_valid}, {31'd0, DS});
      chk("bne_sq_pcsrc", {31'd0, PCSrc}, 32'd0);

      // j 0x40 at id_nPC=0x0400_0001
      IR = 32'h0800_0040; nPC = 32'h0400_0001;
      tick(); #1;
      chk("j_pcsrc",  {31'd0, PCSrc}, 32'd1);
      chk("j_brdest", BrDest, 32'h0400_0040);
      IR = 32'h0; nPC = 32'd5;
      tick(); #1;
      chk("j_sq_valid", {31'd0, id_valid}, {31'd0, DS});

      // beq r3,r0 with r3=0, writeback of r3=7 in the same cycle
      IR = 32'h1060_0001; nPC = 32'd20;
      tick(); #1;
      chk("r3_pre_rdata1", rdata1, 32'd0);
      chk("r3_pre_pcsrc",  {31'd0, PCSrc}, 32'd1);
      RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'd7; #1;
      chk("r3_byp_rdata1", rdata1, 32'd7);
      chk("r3_byp_pcsrc",  {31'd0, PCSrc}, 32'd0);
      tick();
      WriteReg = 5'd0; WriteData = 32'd9; #1;
      chk("r0_wr_rdata2", rdata2, 32'd0);
      chk("r3_rf_rdata1", rdata1, 32'd7);
      chk("r0_wr_pcsrc",  {31'd0, PCSrc}, 32'd0);
      tick(); RegWrite = 1'b0; #1;
      chk("r0_after_rdata2", rdata2, 32'd0);

      // taken beq r1,r1,+2 held by a two-cycle stall
      IR = 32'h1021_0002; nPC = 32'd30;
      tick(); #1;
      chk("stl_pre_pcsrc",  {31'd0, PCSrc}, 32'd1);
      chk("stl_pre_brdest", BrDest, 32'd32);
      stall = 1'b1; #1;
      chk("stl_pcsrc0", {31'd0, PCSrc}, 32'd0);
      IR = 32'h0; nPC = 32'd99;
      tick(); #1;
      chk("stl1_npc",    id_nPC, 32'd30);
      chk("stl1_opcode", {26'd0, opcode}, 32'h04);
      chk("stl1_pcsrc",  {31'd0, PCSrc}, 32'd0);
      tick(); #1;
      chk("stl2_npc",   id_nPC, 32'd30);
      chk("stl2_valid", {31'd0, id_valid}, 32'd1);
      stall = 1'b0; #1;
      chk("stl_rel_pcsrc",  {31'd0, PCSrc}, 32'd1);
      chk("stl_rel_brdest", BrDest, 32'd32);
      tick(); #1;
      chk("stl_sq_valid", {31'd0, id_valid}, {31'd0, DS});
      chk("stl_sq_npc",   id_nPC, 32'd99);

      // asynchronous reset while a taken branch sits in ID
      IR = 32'h1021_0002; nPC = 32'd40;
      tick(); #1;
      chk("ar_pre_pcsrc", {31'd0, PCSrc}, 32'd1);
      #1 reset = 1'b0; #1;
      chk("ar_pcsrc",  {31'd0, PCSrc}, 32'd0);
      chk("ar_valid",  {31'd0, id_valid}, 32'd0);
      chk("ar_brdest", BrDest, 32'd0);
      @(posedge clk); #1 reset = 1'b1;
      IR = 32'h1022_0000; nPC = 32'd50;     // beq r1,r2 after reset: both cleared
      tick(); #1;
      chk("ar_r1_cleared", rdata1, 32'd0);
      chk("ar_post_pcsrc", {31'd0, PCSrc}, 32'd1);
      chk("ar_post_brdest", BrDest, 32'd50);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
